// File: rtl/moments_pkg.sv
// Shared types and width helpers for the moments frame controller and its accumulator.
package moments_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACCUM
    } mfc_state_t;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int min_acc_w(input int img_w, input int img_h);
        return $clog2(longint'(img_w) * longint'(img_h) * longint'(img_w));
    endfunction

    localparam int X_W = cnt_w(DEF_IMG_W);
    localparam int Y_W = cnt_w(DEF_IMG_H);

endpackage

// File: rtl/moments_accum.sv
// Two-stage threshold and accumulate pipeline for the raw moments m00, m10 and m01.
module moments_accum
    import moments_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int ACC_W = 32,
    parameter int XW    = X_W,
    parameter int YW    = Y_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pix_valid,
    input  logic             pix_last,
    input  logic [PIX_W-1:0] pix_data,
    input  logic [PIX_W-1:0] threshold,
    input  logic [XW-1:0]    pix_x,
    input  logic [YW-1:0]    pix_y,
    output logic [ACC_W-1:0] acc00,
    output logic [ACC_W-1:0] acc10,
    output logic [ACC_W-1:0] acc01,
    output logic             frame_done
);

    logic             s1_hit_q, s1_hit_d;
    logic             s1_last_q, s1_last_d;
    logic [XW-1:0]    s1_x_q, s1_x_d;
    logic [YW-1:0]    s1_y_q, s1_y_d;
    logic [ACC_W-1:0] acc00_q, acc00_d;
    logic [ACC_W-1:0] acc10_q, acc10_d;
    logic [ACC_W-1:0] acc01_q, acc01_d;
    logic             done_q, done_d;

    // A completed frame restarts the sums from the pixel already in stage 1,
    // so a back-to-back SOF is not lost; clear discards everything in flight.
    always_comb begin
        s1_hit_d  = pix_valid && (pix_data >= threshold);
        s1_last_d = pix_last;
        s1_x_d    = pix_x;
        s1_y_d    = pix_y;
        acc00_d   = done_q ? '0 : acc00_q;
        acc10_d   = done_q ? '0 : acc10_q;
        acc01_d   = done_q ? '0 : acc01_q;
        if (s1_hit_q) begin
            acc00_d = acc00_d + ACC_W'(1);
            acc10_d = acc10_d + ACC_W'(s1_x_q);
            acc01_d = acc01_d + ACC_W'(s1_y_q);
        end
        if (clear) begin
            acc00_d = '0;
            acc10_d = '0;
            acc01_d = '0;
        end
        done_d = s1_last_q && !clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            acc00_q   <= '0;
            acc10_q   <= '0;
            acc01_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            s1_hit_q  <= s1_hit_d;
            s1_last_q <= s1_last_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            acc00_q   <= acc00_d;
            acc10_q   <= acc10_d;
            acc01_q   <= acc01_d;
            done_q    <= done_d;
        end
    end

    assign acc00      = acc00_q;
    assign acc10      = acc10_q;
    assign acc01      = acc01_q;
    assign frame_done = done_q;

endmodule

// File: rtl/moments_frame_ctrl.sv
// Frame sequencer: arms on start, tracks x/y over one AXI4-Stream frame, flags size errors
// and latches the raw moments produced by moments_accum.
module moments_frame_ctrl
    import moments_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic [PIX_W-1:0] threshold,
    input  logic [PIX_W-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tuser,
    input  logic             s_tlast,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ACC_W-1:0] m00,
    output logic [ACC_W-1:0] m10,
    output logic [ACC_W-1:0] m01,
    output logic [15:0]      frame_cnt
);

    localparam int XW = cnt_w(IMG_W);
    localparam int YW = cnt_w(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    if (ACC_W < min_acc_w(IMG_W, IMG_H)) begin : g_acc_w_check
        $error("moments_frame_ctrl: ACC_W too narrow for IMG_W/IMG_H");
    end

    mfc_state_t       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             over_q, over_d;
    logic             tready_q, tready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [ACC_W-1:0] m00_q, m00_d;
    logic [ACC_W-1:0] m10_q, m10_d;
    logic [ACC_W-1:0] m01_q, m01_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             beat, take, pix_valid, pix_last, clear;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic             cur_over;
    logic [ACC_W-1:0] acc00, acc10, acc01;
    logic             acc_done;

    assign beat = s_tvalid && tready_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        over_d    = over_q;
        tready_d  = 1'b1;
        done_d    = done_q;
        err_d     = err_q;
        m00_d     = m00_q;
        m10_d     = m10_q;
        m01_d     = m01_q;
        cnt_d     = cnt_q;
        take      = 1'b0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        clear     = 1'b0;
        cur_x     = x_q;
        cur_y     = y_q;
        cur_over  = over_q;

        if (abort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            over_d  = 1'b0;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = WAIT_SOF;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        x_d     = '0;
                        y_d     = '0;
                        over_d  = 1'b0;
                    end
                end
                WAIT_SOF: begin
                    if (beat && s_tuser) begin
                        take     = 1'b1;
                        state_d  = ACCUM;
                        cur_x    = '0;
                        cur_y    = '0;
                        cur_over = 1'b0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        take = 1'b1;
                        if (s_tuser) begin
                            err_d    = 1'b1;
                            clear    = 1'b1;
                            cur_x    = '0;
                            cur_y    = '0;
                            cur_over = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Beats past the end of an over-long line only advance y on their tlast.
            if (take) begin
                x_d       = cur_x;
                y_d       = cur_y;
                over_d    = cur_over;
                pix_valid = !cur_over;
                if (s_tlast) begin
                    if (!cur_over && cur_x != X_LAST) err_d = 1'b1;
                    x_d    = '0;
                    over_d = 1'b0;
                    if (cur_y == Y_LAST) begin
                        pix_last = 1'b1;
                        y_d      = '0;
                        state_d  = cont ? WAIT_SOF : IDLE;
                    end else begin
                        y_d = cur_y + 1'b1;
                    end
                end else if (!cur_over) begin
                    if (cur_x == X_LAST) begin
                        over_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        x_d = cur_x + 1'b1;
                    end
                end
            end

            if (acc_done) begin
                m00_d  = acc00;
                m10_d  = acc10;
                m01_d  = acc01;
                done_d = 1'b1;
                cnt_d  = cnt_q + 16'd1;
            end
        end

        busy_d = (state_d == WAIT_SOF) || (state_d == ACCUM);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            over_q   <= 1'b0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            m00_q    <= '0;
            m10_q    <= '0;
            m01_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            over_q   <= over_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            m00_q    <= m00_d;
            m10_q    <= m10_d;
            m01_q    <= m01_d;
            cnt_q    <= cnt_d;
        end
    end

    moments_accum #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W),
        .XW    (XW),
        .YW    (YW)
    ) u_accum (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .clear      (clear),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_data   (s_tdata),
        .threshold  (threshold),
        .pix_x      (cur_x),
        .pix_y      (cur_y),
        .acc00      (acc00),
        .acc10      (acc10),
        .acc01      (acc01),
        .frame_done (acc_done)
    );

    assign s_tready  = tready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign m00       = m00_q;
    assign m10       = m10_q;
    assign m01       = m01_q;
    assign frame_cnt = cnt_q;

endmodule
